// File: rtl/bank_joltage_select_pkg.sv
// Shared constants, FSM encoding and width helper for the day-3 bank joltage pipeline.
package day3_pkg;

  localparam int DIGIT_W = 4;
  localparam int MAX_K   = 12;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CONVERT = 2'd1,
    EMIT    = 2'd2
  } state_t;

  // Smallest width (at least 1) able to index n distinct values.
  function automatic int ceil_log2(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/bank_horner_conv.sv
// Serial Horner converter: folds K decimal slots (slot 0 most significant) into
// a binary value, one digit per cycle, starting one cycle after i_start.
module bank_horner_conv
  import day3_pkg::*;
#(
  parameter int K     = 2,
  parameter int OUT_W = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [K*DIGIT_W-1:0] i_slots,
  output logic                 o_done,
  output logic [OUT_W-1:0]     o_acc
);

  localparam int PTR_W = ceil_log2(K);

  logic               r_busy;
  logic [PTR_W-1:0]   r_ptr;
  logic [OUT_W-1:0]   r_acc;
  logic [DIGIT_W-1:0] w_digit;
  logic [OUT_W-1:0]   w_acc_next;

  // Digit mux and acc*10 + digit; o_done marks the cycle whose edge lands the final digit.
  always_comb begin
    w_digit = '0;
    for (int j = 0; j < K; j++) begin
      if (int'(r_ptr) == j) begin
        w_digit = i_slots[j*DIGIT_W +: DIGIT_W];
      end else begin
        w_digit = w_digit;
      end
    end
    w_acc_next = (r_acc << 3) + (r_acc << 1) + {{(OUT_W-DIGIT_W){1'b0}}, w_digit};
    o_done     = r_busy && (int'(r_ptr) == K - 1);
  end

  // Accumulator and pointer sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_ptr  <= '0;
      r_acc  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_ptr  <= '0;
      r_acc  <= '0;
    end else if (r_busy) begin
      r_acc <= w_acc_next;
      r_ptr <= r_ptr + 1'b1;
      if (o_done) r_busy <= 1'b0;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/bank_joltage_select.sv
// Streams one bank of decimal digits, greedily keeps the K digits forming the
// largest number, converts it to binary and offers it over valid/ready.
module bank_joltage_select
  import day3_pkg::*;
#(
  parameter int LINE_LEN = 100,
  parameter int K        = 2,
  parameter int OUT_W    = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DIGIT_W-1:0] in_digit,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_value,
  output logic               err
);

  localparam int IDX_W  = ceil_log2(LINE_LEN);
  localparam int SIZE_W = ceil_log2(K + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_LEN - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [IDX_W-1:0]     r_idx;
  logic [SIZE_W-1:0]    r_size;
  logic [DIGIT_W-1:0]   r_slot [K];
  logic                 r_err;

  logic                 w_beat;
  logic                 w_bad_digit;
  logic                 w_overrun;
  logic                 w_early_last;
  logic                 w_start;
  logic                 w_emit_done;
  logic                 w_conv_done;
  logic [DIGIT_W-1:0]   w_digit;
  logic [K-1:0]         w_hit;
  logic                 w_found;
  logic [SIZE_W-1:0]    w_sel;
  logic [K*DIGIT_W-1:0] w_slot_vec;
  int                   w_lo;
  int                   w_hi;

  function automatic logic [SIZE_W-1:0] first_hit(input logic [K-1:0] hit);
    logic [SIZE_W-1:0] sel;
    sel = '0;
    for (int j = K - 1; j >= 0; j--) begin
      if (hit[j]) sel = SIZE_W'(j);
    end
    return sel;
  endfunction

  // Beat qualification and error classification.
  always_comb begin
    w_beat       = in_valid && (r_state == COLLECT);
    w_bad_digit  = (in_digit > DIGIT_W'(9));
    w_digit      = w_bad_digit ? '0 : in_digit;
    w_overrun    = (r_idx == LAST_IDX) && !in_last;
    w_early_last = in_last && (r_idx != LAST_IDX);
    w_start      = w_beat && in_last;
    w_emit_done  = (r_state == EMIT) && out_ready;
  end

  // Single-cycle greedy slot choice; lo reserves room for the digits still to come.
  always_comb begin
    w_lo  = (K > LINE_LEN - int'(r_idx)) ? (K - LINE_LEN + int'(r_idx)) : 0;
    w_hi  = (int'(r_size) < K - 1) ? int'(r_size) : (K - 1);
    w_hit = '0;
    for (int j = 0; j < K; j++) begin
      w_hit[j] = (j >= w_lo) && (j <= w_hi) &&
                 ((j == int'(r_size)) || (w_digit > r_slot[j]));
    end
    w_found = |w_hit;
    w_sel   = first_hit(w_hit);
  end

  // Slots beyond size are stale and must read as zero for the converter.
  always_comb begin
    w_slot_vec = '0;
    for (int j = 0; j < K; j++) begin
      w_slot_vec[j*DIGIT_W +: DIGIT_W] = (j < int'(r_size)) ? r_slot[j] : '0;
    end
  end

  // FSM next-state and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    in_ready     = (r_state == COLLECT);
    out_valid    = (r_state == EMIT);
    case (r_state)
      COLLECT: w_state_next = w_start     ? CONVERT : COLLECT;
      CONVERT: w_state_next = w_conv_done ? EMIT    : CONVERT;
      EMIT:    w_state_next = out_ready   ? COLLECT : EMIT;
      default: w_state_next = COLLECT;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Slot, index and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= '0;
      r_size <= '0;
      r_err  <= 1'b0;
      for (int j = 0; j < K; j++) r_slot[j] <= '0;
    end else begin
      if (w_beat && (w_bad_digit || w_early_last || w_overrun)) r_err <= 1'b1;
      if (w_emit_done) begin
        r_idx  <= '0;
        r_size <= '0;
        for (int j = 0; j < K; j++) r_slot[j] <= '0;
      end else if (w_beat && !w_overrun) begin
        if (w_found) begin
          r_slot[w_sel] <= w_digit;
          r_size        <= w_sel + 1'b1;
        end
        if (!in_last) r_idx <= r_idx + 1'b1;
      end
    end
  end

  bank_horner_conv #(
    .K     (K),
    .OUT_W (OUT_W)
  ) u_conv (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_slots (w_slot_vec),
    .o_done  (w_conv_done),
    .o_acc   (out_value)
  );

  assign err = r_err;

endmodule

// File: tb/tb_bank_joltage_select.sv
// Directed bench: LINE_LEN=15 pair (K=2, K=12) sharing one stream, plus a
// LINE_LEN=100 pair checked against a window-maximum reference.
module tb_bank_joltage_select;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_valid, a_last, a_oready;
  logic [3:0]  a_digit;
  logic        a2_iready, a2_ovalid, a2_err, a12_iready, a12_ovalid, a12_err;
  logic [39:0] a2_oval, a12_oval;

  logic        b_valid, b_last, b_oready;
  logic [3:0]  b_digit;
  logic        b2_iready, b2_ovalid, b2_err, b12_iready, b12_ovalid, b12_err;
  logic [39:0] b2_oval, b12_oval;

  logic [63:0] a2_q[$], a12_q[$], b2_q[$], b12_q[$];
  int n_checks = 0;
  int n_err    = 0;

  bank_joltage_select #(.LINE_LEN(15), .K(2), .OUT_W(40)) u_a2 (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a2_iready), .in_digit(a_digit),
    .in_last(a_last), .out_valid(a2_ovalid), .out_ready(a_oready), .out_value(a2_oval), .err(a2_err));
  bank_joltage_select #(.LINE_LEN(15), .K(12), .OUT_W(40)) u_a12 (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a12_iready), .in_digit(a_digit),
    .in_last(a_last), .out_valid(a12_ovalid), .out_ready(a_oready), .out_value(a12_oval), .err(a12_err));
  bank_joltage_select #(.LINE_LEN(100), .K(2), .OUT_W(40)) u_b2 (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b2_iready), .in_digit(b_digit),
    .in_last(b_last), .out_valid(b2_ovalid), .out_ready(b_oready), .out_value(b2_oval), .err(b2_err));
  bank_joltage_select #(.LINE_LEN(100), .K(12), .OUT_W(40)) u_b12 (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b12_iready), .in_digit(b_digit),
    .in_last(b_last), .out_valid(b12_ovalid), .out_ready(b_oready), .out_value(b12_oval), .err(b12_err));

  // Record every completed output handshake.
  always @(posedge clk) begin
    if (!rst && a_oready && a2_ovalid)  a2_q.push_back(64'(a2_oval));
    if (!rst && a_oready && a12_ovalid) a12_q.push_back(64'(a12_oval));
    if (!rst && b_oready && b2_ovalid)  b2_q.push_back(64'(b2_oval));
    if (!rst && b_oready && b12_ovalid) b12_q.push_back(64'(b12_oval));
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one bank; returns at the negedge just after the in_last handshake edge.
  task automatic send_a(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      a_valid = 1'b1;
      a_digit = 4'(s[i] - 8'd48);
      a_last  = (i == s.len() - 1);
    end
    @(negedge clk);
    a_valid = 1'b0;
    a_last  = 1'b0;
    a_digit = 4'd0;
  endtask

  logic [63:0] sum2, sum12;

  task automatic expect_a(input string tag, input logic [63:0] e2, input logic [63:0] e12);
    int n;
    logic [63:0] v;
    n = 0;
    while ((a2_q.size() == 0 || a12_q.size() == 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " timeout"}, 64'(a2_q.size() > 0 && a12_q.size() > 0), 64'd1);
    if (a2_q.size() > 0) begin
      v = a2_q.pop_front();
      sum2 += v;
      chk({tag, " k2"}, v, e2);
    end
    if (a12_q.size() > 0) begin
      v = a12_q.pop_front();
      sum12 += v;
      chk({tag, " k12"}, v, e12);
    end
  endtask

  task automatic send_b(input int d[100]);
    for (int i = 0; i < 100; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        b_valid  = 1'b0;
        b_oready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      b_valid  = 1'b1;
      b_digit  = 4'(d[i]);
      b_last   = (i == 99);
      b_oready = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    b_valid = 1'b0;
    b_last  = 1'b0;
  endtask

  task automatic expect_b(input string tag, input logic [63:0] e2, input logic [63:0] e12);
    int n;
    n = 0;
    while ((b2_q.size() == 0 || b12_q.size() == 0) && n < 400) begin
      @(negedge clk);
      b_oready = 1'($urandom_range(0, 1));
      n++;
    end
    chk({tag, " timeout"}, 64'(b2_q.size() > 0 && b12_q.size() > 0), 64'd1);
    if (b2_q.size() > 0)  chk({tag, " k2"},  b2_q.pop_front(),  e2);
    if (b12_q.size() > 0) chk({tag, " k12"}, b12_q.pop_front(), e12);
  endtask

  // Reference: for each output position take the leftmost maximum of the legal window.
  function automatic logic [63:0] best_num(input int d[100], input int k);
    logic [63:0] v;
    int start, m;
    v = 64'd0;
    start = 0;
    for (int p = 0; p < k; p++) begin
      m = start;
      for (int i = start; i <= 100 - k + p; i++) begin
        if (d[i] > d[m]) m = i;
      end
      v = v * 64'd10 + 64'(d[m]);
      start = m + 1;
    end
    return v;
  endfunction

  string       banks [4];
  logic [63:0] exp2 [4];
  logic [63:0] exp12 [4];
  int          rd [100];

  initial begin
    banks = '{"987654321111111", "811111111111119", "234234234234278", "818181911112111"};
    exp2  = '{64'd98, 64'd89, 64'd78, 64'd92};
    exp12 = '{64'd987654321111, 64'd811111111119, 64'd434234234278, 64'd888911112111};
    rst = 1'b1;
    a_valid = 1'b0; a_last = 1'b0; a_digit = 4'd0; a_oready = 1'b0;
    b_valid = 1'b0; b_last = 1'b0; b_digit = 4'd0; b_oready = 1'b0;
    sum2 = 64'd0; sum12 = 64'd0;
    repeat (3) @(negedge clk);

    chk("reset a2 rdy/vld/err",  {a2_iready, a2_ovalid, a2_err},    3'b100);
    chk("reset a12 rdy/vld/err", {a12_iready, a12_ovalid, a12_err}, 3'b100);
    chk("reset b12 rdy/vld/err", {b12_iready, b12_ovalid, b12_err}, 3'b100);
    chk("reset a12 value", a12_oval, 64'd0);
    rst = 1'b0;

    // Result appears exactly two edges after the in_last handshake for K=2.
    a_oready = 1'b1;
    send_a("987654321111111");
    chk("latency edge1 valid", a2_ovalid, 64'd0);
    @(negedge clk);
    chk("latency edge2 valid", a2_ovalid, 64'd0);
    @(negedge clk);
    chk("latency edge3 valid", a2_ovalid, 64'd1);
    chk("latency value", a2_oval, 64'd98);
    expect_a("latency bank", 64'd98, 64'd987654321111);
    chk("latency err", {a2_err, a12_err}, 2'b00);

    sum2 = 64'd0; sum12 = 64'd0;
    for (int i = 0; i < 4; i++) begin
      send_a(banks[i]);
      expect_a($sformatf("bank%0d", i), exp2[i], exp12[i]);
    end
    chk("sum k2", sum2, 64'd357);
    chk("sum k12", sum12, 64'd3121910778619);

    // Backpressure: both results held while offered digits are refused.
    a_oready = 1'b0;
    send_a("818181911112111");
    repeat (14) @(negedge clk);
    a_valid = 1'b1;
    a_digit = 4'd9;
    chk("bp valid", {a2_ovalid, a12_ovalid, a2_iready, a12_iready}, 4'b1100);
    chk("bp k2 early", a2_oval, 64'd92);
    chk("bp k12 early", a12_oval, 64'd888911112111);
    repeat (20) @(negedge clk);
    chk("bp held", {a2_ovalid, a12_ovalid, a2_iready, a12_iready}, 4'b1100);
    chk("bp k2 late", a2_oval, 64'd92);
    chk("bp k12 late", a12_oval, 64'd888911112111);
    chk("bp queue empty", 64'(a2_q.size() + a12_q.size()), 64'd0);
    a_valid  = 1'b0;
    a_oready = 1'b1;
    expect_a("bp release", 64'd92, 64'd888911112111);
    send_a("987654321111111");
    expect_a("bp next bank", 64'd98, 64'd987654321111);
    chk("bp err", {a2_err, a12_err}, 2'b00);

    // '<' encodes digit value 12, which must be consumed as 0.
    send_a("1111111111119<0");
    expect_a("bad digit", 64'd90, 64'd111111111900);
    chk("bad digit err", {a2_err, a12_err}, 2'b11);
    pulse_reset();
    chk("err cleared", {a2_err, a12_err}, 2'b00);

    send_a("987654");
    expect_a("early last", 64'd98, 64'd987654000000);
    chk("early last err", {a2_err, a12_err}, 2'b11);
    pulse_reset();

    // Reset while converting discards the bank.
    send_a("811111111111119");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst conv state", {a2_ovalid, a12_ovalid, a2_iready, a12_iready}, 4'b0011);
    repeat (15) @(negedge clk);
    chk("rst conv no output", 64'(a2_q.size() + a12_q.size()), 64'd0);
    send_a("234234234234278");
    expect_a("after rst", 64'd78, 64'd434234234278);
    chk("after rst err", {a2_err, a12_err}, 2'b00);

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 100; i++) rd[i] = int'($urandom_range(0, 9));
      send_b(rd);
      expect_b($sformatf("rand%0d", t), best_num(rd, 2), best_num(rd, 12));
    end
    chk("rand err", {b2_err, b12_err}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
